// File: rtl/bcd_7seg_scan_driver.sv
// Purpose : multiplexed 3-digit 7-segment driver fed by a packed BCD value,
//           with a shadow register, leading-zero blanking and dash for nibbles >9.
// Latency : seg/an registered; 1 cycle from index change or shadow load to outputs.
// Backpressure: none; bcd_load is accepted on any cycle, with no handshake back.
//
// Ports:
//   clk, rst_n  - clock (rising edge) and asynchronous active-low reset
//   bcd_in      - {hundreds, tens, units} BCD nibbles, sampled when bcd_load = 1
//   bcd_load    - shadow-register capture strobe
//   blank_lz    - 1 = blank leading zeros in the hundreds and tens digits
//   seg         - {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   an          - {hundreds, tens, units} digit enables, polarity set by AN_ACTIVE_LOW
//   frame_tick  - one-cycle pulse on the cycle an returns from hundreds to units
module bcd_7seg_scan_driver #(
   parameter int unsigned CLK_DIV        = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] bcd_in,
   input  logic        bcd_load,
   input  logic        blank_lz,
   output logic [6:0]  seg,
   output logic [2:0]  an,
   output logic        frame_tick
);

   // 20 bits covers CLK_DIV up to 2^20 (max count 2^20-1).
   localparam logic [19:0] PRESC_MAX = 20'(CLK_DIV - 1);
   localparam logic [6:0]  SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0]  AN_OFF    = AN_ACTIVE_LOW  ? 3'b111 : 3'b000;

   logic [11:0] shadow;
   logic [19:0] presc;
   logic [1:0]  idx;
   logic        wrap;        // index just wrapped 2 -> 0; becomes frame_tick next cycle
   logic [3:0]  nib;
   logic        blank;
   logic [2:0]  sel;
   logic [6:0]  seg_hi;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h40;             // nibbles A..F show a dash
      case (n)
         4'd0: s = 7'h3F;
         4'd1: s = 7'h06;
         4'd2: s = 7'h5B;
         4'd3: s = 7'h4F;
         4'd4: s = 7'h66;
         4'd5: s = 7'h6D;
         4'd6: s = 7'h7D;
         4'd7: s = 7'h07;
         4'd8: s = 7'h7F;
         4'd9: s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Digit mux and decode from the current shadow and index. A nibble >9 is
   // never equal to zero, so it is never blanked and shows the dash.
   always_comb begin
      nib   = shadow[3:0];
      blank = 1'b0;
      sel   = 3'b001;
      case (idx)
         2'd1: begin
            nib   = shadow[7:4];
            blank = blank_lz && (shadow[11:8] == 4'd0) && (shadow[7:4] == 4'd0);
            sel   = 3'b010;
         end
         2'd2: begin
            nib   = shadow[11:8];
            blank = blank_lz && (shadow[11:8] == 4'd0);
            sel   = 3'b100;
         end
         default: begin
            nib   = shadow[3:0];
            blank = 1'b0;
            sel   = 3'b001;
         end
      endcase
      seg_hi = blank ? 7'h00 : decode(nib);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow     <= 12'h000;
         presc      <= 20'd0;
         idx        <= 2'd0;
         wrap       <= 1'b0;
         seg        <= SEG_OFF;
         an         <= AN_OFF;
         frame_tick <= 1'b0;
      end else begin
         // A load never disturbs the scan phase.
         if (bcd_load) shadow <= bcd_in;

         wrap <= 1'b0;
         if (presc == PRESC_MAX) begin
            presc <= 20'd0;
            idx   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            wrap  <= (idx == 2'd2);
         end else begin
            presc <= presc + 20'd1;
         end

         seg        <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
         an         <= AN_ACTIVE_LOW  ? ~sel    : sel;
         frame_tick <= wrap;
      end
   end

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
// Bench for bcd_7seg_scan_driver with CLK_DIV = 4, active-low segments and anodes.
// A cycle-count reference model pushes one expected {seg, an, frame_tick} per clock;
// the negedge checker pops and compares. Directed table vectors and corner sequences
// run on top of it.
module tb_bcd_7seg_scan_driver;

   localparam int DIV = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] bcd_in;
   logic        bcd_load;
   logic        blank_lz;
   logic [6:0]  seg;
   logic [2:0]  an;
   logic        frame_tick;

   int n_checks = 0;
   int n_fail   = 0;

   bcd_7seg_scan_driver #(
      .CLK_DIV        (DIV),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bcd_in     (bcd_in),
      .bcd_load   (bcd_load),
      .blank_lz   (blank_lz),
      .seg        (seg),
      .an         (an),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   typedef struct packed {
      logic [6:0] seg;
      logic [2:0] an;
      logic       tick;
   } exp_t;

   localparam logic [6:0] LUT [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

   function automatic logic [6:0] ref_seg(input logic [11:0] v, input int slot, input logic blz);
      logic [6:0] code;
      logic [3:0] n;
      n = (slot == 0) ? v[3:0] : (slot == 1) ? v[7:4] : v[11:8];
      code = LUT[n];
      if (slot == 2 && blz && v[11:8] == 4'd0) code = 7'h00;
      if (slot == 1 && blz && v[11:8] == 4'd0 && v[7:4] == 4'd0) code = 7'h00;
      return ~code;
   endfunction

   exp_t        sb[$];
   exp_t        m_e;
   int          m_n;      // output cycles since reset release
   int          m_slot;
   logic [11:0] m_sh;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n  = 0;
         m_sh = 12'h000;
         sb.delete();
      end else begin
         m_n++;
         m_slot   = ((m_n - 1) / DIV) % 3;
         m_e.seg  = ref_seg(m_sh, m_slot, blank_lz);
         m_e.an   = ~(3'b001 << m_slot);
         m_e.tick = (m_n > 1) && (((m_n - 1) % (3 * DIV)) == 0);
         sb.push_back(m_e);
         if (bcd_load) m_sh = bcd_in;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         check("reset_outputs", 32'({seg, an, frame_tick}), 32'({7'h7F, 3'b111, 1'b0}));
      end else if (sb.size() > 0) begin
         e = sb.pop_front();
         check("scan_cycle", 32'({seg, an, frame_tick}), 32'(e));
      end
   end

   // ---------------- directed stimulus ----------------
   typedef struct {
      logic [11:0] bcd;
      logic        blz;
      logic [6:0]  seg_u;
      logic [6:0]  seg_t;
      logic [6:0]  seg_h;
   } vec_t;

   vec_t vecs[8];

   task automatic wait_an(input logic [2:0] v, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (an == v) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_an: an never reached %b (stuck at %b)", v, an);
      end
   endtask

   task automatic count_to_tick(input string name, input int expected);
      int cnt;
      cnt = 0;
      do begin
         @(negedge clk);
         cnt++;
      end while (!frame_tick && cnt < 60);
      check(name, 32'(cnt), 32'(expected));
   endtask

   initial begin
      bit ok;
      vecs[0] = '{12'h125, 1'b0, 7'h12, 7'h24, 7'h79};
      vecs[1] = '{12'h005, 1'b1, 7'h12, 7'h7F, 7'h7F};
      vecs[2] = '{12'h005, 1'b0, 7'h12, 7'h40, 7'h40};
      vecs[3] = '{12'h0A0, 1'b1, 7'h40, 7'h3F, 7'h7F};
      vecs[4] = '{12'h000, 1'b1, 7'h40, 7'h7F, 7'h7F};
      vecs[5] = '{12'h999, 1'b1, 7'h10, 7'h10, 7'h10};
      vecs[6] = '{12'h0F7, 1'b1, 7'h78, 7'h3F, 7'h7F};
      vecs[7] = '{12'h100, 1'b1, 7'h40, 7'h40, 7'h79};

      rst_n    = 1'b0;
      bcd_in   = 12'h000;
      bcd_load = 1'b0;
      blank_lz = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // First cycle after release: units "0".
      @(negedge clk);
      check("first_an", 32'(an), 32'(3'b110));
      check("first_seg", 32'(seg), 32'(7'h40));

      // frame_tick spacing.
      count_to_tick("first_tick_delay", 3 * DIV);
      count_to_tick("tick_period", 3 * DIV);

      // Table vectors: load, let a full frame pass, then sample each slot.
      for (int i = 0; i < 8; i++) begin
         bcd_in   = vecs[i].bcd;
         blank_lz = vecs[i].blz;
         bcd_load = 1'b1;
         @(negedge clk);
         bcd_load = 1'b0;
         repeat (3 * DIV) @(negedge clk);
         wait_an(3'b110, ok);
         if (ok) check($sformatf("vec%0d_units", i), 32'(seg), 32'(vecs[i].seg_u));
         wait_an(3'b101, ok);
         if (ok) check($sformatf("vec%0d_tens", i), 32'(seg), 32'(vecs[i].seg_t));
         wait_an(3'b011, ok);
         if (ok) check($sformatf("vec%0d_hundreds", i), 32'(seg), 32'(vecs[i].seg_h));
      end

      // Load coincident with the tens -> hundreds index advance.
      bcd_in   = 12'h200;
      blank_lz = 1'b0;
      bcd_load = 1'b1;
      @(negedge clk);
      bcd_load = 1'b0;
      repeat (3 * DIV) @(negedge clk);
      wait_an(3'b110, ok);
      wait_an(3'b101, ok);           // first tens cycle
      repeat (DIV - 2) @(negedge clk);
      bcd_in   = 12'h300;
      bcd_load = 1'b1;               // sampled on the edge that advances the index
      @(negedge clk);
      bcd_load = 1'b0;
      check("coincident_phase_tens", 32'(an), 32'(3'b101));
      @(negedge clk);
      check("coincident_an", 32'(an), 32'(3'b011));
      check("coincident_seg", 32'(seg), 32'(7'h30));

      // Reset pulse in the middle of the hundreds slot.
      wait_an(3'b110, ok);
      wait_an(3'b011, ok);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_seg", 32'(seg), 32'(7'h7F));
      check("async_reset_an", 32'(an), 32'(3'b111));
      check("async_reset_tick", 32'(frame_tick), 32'(1'b0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_reset_an", 32'(an), 32'(3'b110));
      check("post_reset_seg", 32'(seg), 32'(7'h40));
      count_to_tick("post_reset_tick_delay", 3 * DIV);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, time %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
